pe_dmem_scatter_ctrl: RTL and testbench



---
 rtl/pe_dmem_scatter_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_pe_dmem_scatter_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_dmem_scatter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pe_dmem_scatter_ctrl
// Purpose  : Host-side sequencer for port A of all PE data memories. Scatters
//            a linear host word stream across the PEs (word k -> lane
//            k mod PE_NUM, row base + k/PE_NUM) and gathers it back on reads.
// Options  : PE_DMEM_BCAST_EN - when defined, a write command with
//            iCmd_Bcast=1 writes every word to all lanes at row base + k.
// Revision : 1.0 - initial release
// ============================================================================
module pe_dmem_scatter_ctrl #(
    parameter int PE_NUM = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                       iClk,
    input  logic                       iReset_n,
    input  logic                       iCmd_Valid,
    output logic                       oCmd_Ready,
    input  logic                       iCmd_Write,
    input  logic                       iCmd_Bcast,
    input  logic [ADDR_W-1:0]          iCmd_Base,
    input  logic [CNT_W-1:0]           iCmd_Count,
    input  logic                       iWr_Valid,
    output logic                       oWr_Ready,
    input  logic [DATA_W-1:0]          iWr_Data,
    output logic                       oRd_Valid,
    input  logic                       iRd_Ready,
    output logic [DATA_W-1:0]          oRd_Data,
    output logic                       oBusy,
    output logic                       oDone,
    output logic [PE_NUM-1:0]          oBus_PE_DMEM_Valid,
    output logic [ADDR_W*PE_NUM-1:0]   oBus_PE_DMEM_Address,
    output logic [DATA_W*PE_NUM-1:0]   oBus_PE_DMEM_Write_Data,
    output logic [PE_NUM-1:0]          oBus_PE_DMEM_Write_Enable,
    input  logic [DATA_W*PE_NUM-1:0]   iBus_PE_DMEM_Read_Data
);

    localparam int LANE_W = $clog2(PE_NUM);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WRITE    = 3'd1,
        S_RD_ISSUE = 3'd2,
        S_RD_WAIT  = 3'd3,
        S_RD_OUT   = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_base;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_k;
    logic [LANE_W-1:0]   r_lane;
    logic [ADDR_W-1:0]   r_row_off;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_rd_valid;

    logic                w_bcast;
    logic                w_wr_fire;
    logic                w_rd_issue;
    logic                w_last;
    logic                w_lane_wrap;
    logic [ADDR_W-1:0]   w_row;
    logic [DATA_W-1:0]   w_rd_slice;
    logic [PE_NUM-1:0]        w_bus_valid;
    logic [PE_NUM-1:0]        w_bus_we;
    logic [ADDR_W*PE_NUM-1:0] w_bus_addr;
    logic [DATA_W*PE_NUM-1:0] w_bus_wdata;

`ifdef PE_DMEM_BCAST_EN
    logic r_bcast;
    assign w_bcast = r_bcast;

    // Broadcast flag is latched with the command; only meaningful for writes
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_bcast <= 1'b0;
        end else if (r_state == S_IDLE && iCmd_Valid) begin
            r_bcast <= iCmd_Bcast & iCmd_Write;
        end
    end
`else
    logic w_unused_bcast;
    assign w_unused_bcast = iCmd_Bcast;
    assign w_bcast        = 1'b0;
`endif

    assign w_wr_fire   = (r_state == S_WRITE) && iWr_Valid;
    assign w_rd_issue  = (r_state == S_RD_ISSUE);
    assign w_last      = (r_k == (r_count - CNT_W'(1)));
    assign w_lane_wrap = (r_lane == LANE_W'(PE_NUM - 1));
    assign w_row       = r_base + r_row_off;
    assign w_rd_slice  = iBus_PE_DMEM_Read_Data[DATA_W*int'(r_lane) +: DATA_W];

    // Bus strobes are a pure decode of the current state and write handshake
    always_comb begin
        w_bus_valid = '0;
        w_bus_we    = '0;
        w_bus_addr  = '0;
        w_bus_wdata = '0;
        for (int i = 0; i < PE_NUM; i++) begin
            if (w_wr_fire && (w_bcast || r_lane == LANE_W'(i))) begin
                w_bus_valid[i] = 1'b1;
                w_bus_we[i]    = 1'b1;
            end
            if (w_rd_issue && r_lane == LANE_W'(i)) begin
                w_bus_valid[i] = 1'b1;
            end
            if (w_wr_fire || w_rd_issue) begin
                w_bus_addr[ADDR_W*i +: ADDR_W] = w_row;
            end
            if (w_wr_fire) begin
                w_bus_wdata[DATA_W*i +: DATA_W] = iWr_Data;
            end
        end
    end

    // Sequencer: command capture, lane/row stepping and read-data holding
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_count    <= '0;
            r_k        <= '0;
            r_lane     <= '0;
            r_row_off  <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iCmd_Valid) begin
                        r_base    <= iCmd_Base;
                        r_count   <= iCmd_Count;
                        r_k       <= '0;
                        r_lane    <= '0;
                        r_row_off <= '0;
                        if (iCmd_Count == '0) begin
                            r_state <= S_DONE;
                        end else if (iCmd_Write) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_RD_ISSUE;
                        end
                    end
                end
                S_WRITE: begin
                    if (iWr_Valid) begin
                        r_k <= r_k + CNT_W'(1);
                        if (w_bcast) begin
                            r_row_off <= r_row_off + ADDR_W'(1);
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                            if (w_lane_wrap) begin
                                r_row_off <= r_row_off + ADDR_W'(1);
                            end
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD_ISSUE: begin
                    r_state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    r_rd_data  <= w_rd_slice;
                    r_rd_valid <= 1'b1;
                    r_state    <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (iRd_Ready) begin
                        r_rd_valid <= 1'b0;
                        r_k        <= r_k + CNT_W'(1);
                        r_lane     <= r_lane + LANE_W'(1);
                        if (w_lane_wrap) begin
                            r_row_off <= r_row_off + ADDR_W'(1);
                        end
                        r_state <= w_last ? S_DONE : S_RD_ISSUE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign oCmd_Ready                = (r_state == S_IDLE);
    assign oBusy                     = (r_state != S_IDLE);
    assign oDone                     = (r_state == S_DONE);
    assign oWr_Ready                 = (r_state == S_WRITE);
    assign oRd_Valid                 = r_rd_valid;
    assign oRd_Data                  = r_rd_data;
    assign oBus_PE_DMEM_Valid        = w_bus_valid;
    assign oBus_PE_DMEM_Write_Enable = w_bus_we;
    assign oBus_PE_DMEM_Address      = w_bus_addr;
    assign oBus_PE_DMEM_Write_Data   = w_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_pe_dmem_scatter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_dmem_scatter_ctrl
// Purpose  : Scoreboard bench for pe_dmem_scatter_ctrl with a PE DMEM model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pe_dmem_scatter_ctrl;

    localparam int PE   = 4;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int CW   = 16;
    localparam int ROWS = 1 << AW;
`ifdef PE_DMEM_BCAST_EN
    localparam bit BCAST_BUILD = 1'b1;
`else
    localparam bit BCAST_BUILD = 1'b0;
`endif

    logic              iClk = 1'b0;
    logic              iReset_n = 1'b0;
    logic              iCmd_Valid = 1'b0;
    logic              oCmd_Ready;
    logic              iCmd_Write = 1'b0;
    logic              iCmd_Bcast = 1'b0;
    logic [AW-1:0]     iCmd_Base = '0;
    logic [CW-1:0]     iCmd_Count = '0;
    logic              iWr_Valid = 1'b0;
    logic              oWr_Ready;
    logic [DW-1:0]     iWr_Data = '0;
    logic              oRd_Valid;
    logic              iRd_Ready = 1'b0;
    logic [DW-1:0]     oRd_Data;
    logic              oBusy;
    logic              oDone;
    logic [PE-1:0]     bus_v;
    logic [AW*PE-1:0]  bus_addr;
    logic [DW*PE-1:0]  bus_wdata;
    logic [PE-1:0]     bus_we;
    logic [DW*PE-1:0]  bus_rdata = '0;

    pe_dmem_scatter_ctrl #(.PE_NUM(PE), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .iClk(iClk), .iReset_n(iReset_n),
        .iCmd_Valid(iCmd_Valid), .oCmd_Ready(oCmd_Ready), .iCmd_Write(iCmd_Write),
        .iCmd_Bcast(iCmd_Bcast), .iCmd_Base(iCmd_Base), .iCmd_Count(iCmd_Count),
        .iWr_Valid(iWr_Valid), .oWr_Ready(oWr_Ready), .iWr_Data(iWr_Data),
        .oRd_Valid(oRd_Valid), .iRd_Ready(iRd_Ready), .oRd_Data(oRd_Data),
        .oBusy(oBusy), .oDone(oDone),
        .oBus_PE_DMEM_Valid(bus_v), .oBus_PE_DMEM_Address(bus_addr),
        .oBus_PE_DMEM_Write_Data(bus_wdata), .oBus_PE_DMEM_Write_Enable(bus_we),
        .iBus_PE_DMEM_Read_Data(bus_rdata)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [PE-1:0] v;
        logic [PE-1:0] we;
        logic [AW-1:0] row;
        logic [DW-1:0] data;
    } bus_t;

    bus_t          bus_q[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] wdata[$];
    logic [DW-1:0] ref_mem [PE][ROWS];
    logic [DW-1:0] dmem    [PE][ROWS];
    int            checks   = 0;
    int            failures = 0;
    bit            mon_en   = 1'b0;
    bit            clr_mem  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // PE data memories: write on strobe, read data one cycle after a read access
    always @(posedge iClk) begin
        for (int l = 0; l < PE; l++) begin
            if (clr_mem) begin
                for (int r = 0; r < ROWS; r++) dmem[l][r] <= '0;
            end else if (bus_v[l] && bus_we[l]) begin
                dmem[l][bus_addr[AW*l +: AW]] <= bus_wdata[DW*l +: DW];
            end
            bus_rdata[DW*l +: DW] <= (bus_v[l] && !bus_we[l]) ?
                                     dmem[l][bus_addr[AW*l +: AW]] : (32'hDEAD0000 | DW'(l));
        end
    end

    // Monitor: compare every bus access and every read handshake with the queues
    bus_t          mon_e;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;
    always @(negedge iClk) begin
        if (mon_en) begin
            if (|bus_v) begin
                if (bus_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL bus_unexpected actual_valid=0x%0h required=none", bus_v);
                end else begin
                    mon_e = bus_q.pop_front();
                    chk("bus_valid", 64'(bus_v), 64'(mon_e.v));
                    chk("bus_we", 64'(bus_we), 64'(mon_e.we));
                    for (int i = 0; i < PE; i++) begin
                        if (mon_e.v[i]) chk("bus_addr", 64'(bus_addr[AW*i +: AW]), 64'(mon_e.row));
                        if (|mon_e.we) chk("bus_wdata", 64'(bus_wdata[DW*i +: DW]), 64'(mon_e.data));
                    end
                end
            end
            if (prev_stall) begin
                chk("rd_hold_valid", 64'(oRd_Valid), 64'd1);
                chk("rd_hold_data", 64'(oRd_Data), 64'(prev_data));
            end
            if (oRd_Valid && iRd_Ready) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_unexpected actual=0x%0h required=none", oRd_Data);
                end else begin
                    chk("rd_data", 64'(oRd_Data), 64'(rd_q.pop_front()));
                end
            end
            prev_stall = oRd_Valid && !iRd_Ready;
            prev_data  = oRd_Data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Reference: word k -> lane k%PE, row base+k/PE; broadcast -> all lanes, row base+k
    task automatic plan(input bit wr, input bit bc, input int base, input int cnt);
        bus_t e;
        for (int k = 0; k < cnt; k++) begin
            int lane;
            int row;
            lane = k % PE;
            if (wr && bc && BCAST_BUILD) begin
                row    = (base + k) % ROWS;
                e.v    = '1;
                e.we   = '1;
                e.row  = AW'(row);
                e.data = wdata[k];
                for (int l = 0; l < PE; l++) ref_mem[l][row] = wdata[k];
            end else begin
                row    = (base + k / PE) % ROWS;
                e.v    = '0;
                e.v[lane] = 1'b1;
                e.we   = wr ? e.v : '0;
                e.row  = AW'(row);
                e.data = wr ? wdata[k] : '0;
                if (wr) ref_mem[lane][row] = wdata[k];
                else    rd_q.push_back(ref_mem[lane][row]);
            end
            bus_q.push_back(e);
        end
    endtask

    // One command: mode 0 = always ready/valid, 1 = toggling, 2 = random
    task automatic run_cmd(input bit wr, input bit bc, input int base, input int cnt,
                           input int mode, input bit inject, output int done_cyc);
        int k;
        int cyc;
        plan(wr, bc, base, cnt);
        iCmd_Valid = 1'b1; iCmd_Write = wr; iCmd_Bcast = bc;
        iCmd_Base = AW'(base); iCmd_Count = CW'(cnt);
        @(posedge iClk); #1;
        iCmd_Valid = 1'b0; iCmd_Base = AW'($urandom); iCmd_Count = CW'($urandom);
        k = 0; cyc = 0; done_cyc = -1;
        while (done_cyc < 0 && cyc < 2000) begin
            if (wr) begin
                iWr_Valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : ($urandom % 4 != 0);
                iWr_Data  = (k < cnt) ? wdata[k] : DW'($urandom);
            end else begin
                iRd_Ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom % 2);
                iWr_Valid = 1'($urandom % 2);
                iWr_Data  = DW'($urandom);
            end
            if (inject && cyc == 1) begin
                iCmd_Valid = 1'b1; iCmd_Write = ~wr; iCmd_Count = CW'(3);
            end else begin
                iCmd_Valid = 1'b0;
            end
            @(negedge iClk);
            if (inject && cyc == 1) chk("busy_cmd_ready", 64'(oCmd_Ready), 64'd0);
            if (wr && iWr_Valid && oWr_Ready) k++;
            if (oDone) done_cyc = cyc;
            @(posedge iClk); #1;
            cyc++;
        end
        iCmd_Valid = 1'b0; iRd_Ready = 1'b0;
        iWr_Valid  = 1'b1;
        if (done_cyc < 0) chk("done_timeout", 64'd0, 64'd1);
        @(negedge iClk);
        chk("done_single_pulse", 64'(oDone), 64'd0);
        chk("idle_cmd_ready", 64'(oCmd_Ready), 64'd1);
        chk("scoreboard_drained", 64'(bus_q.size() + rd_q.size()), 64'd0);
        if (wr) chk("words_accepted", 64'(k), 64'(cnt));
        @(posedge iClk); #1;
        iWr_Valid = 1'b0;
    endtask

    initial begin
        int dc;
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int l = 0; l < PE; l++)
            for (int r = 0; r < ROWS; r++) ref_mem[l][r] = '0;
        clr_mem = 1'b1;
        repeat (3) @(posedge iClk);
        #3;
        chk("rst_cmd_ready", 64'(oCmd_Ready), 64'd1);
        chk("rst_outputs", {oWr_Ready, oRd_Valid, oBusy, oDone, bus_v, bus_we}, 64'd0);
        chk("rst_rd_data", 64'(oRd_Data), 64'd0);
        chk("rst_bus_data", 64'(|{bus_addr, bus_wdata}), 64'd0);
        @(posedge iClk); #1;
        iReset_n = 1'b1; clr_mem = 1'b0;
        @(posedge iClk); #1;

        // Reset asserted in the middle of a write burst
        iCmd_Valid = 1'b1; iCmd_Write = 1'b1; iCmd_Bcast = 1'b0;
        iCmd_Base = AW'(1); iCmd_Count = CW'(8);
        @(posedge iClk); #1;
        iCmd_Valid = 1'b0; iWr_Valid = 1'b1; iWr_Data = 32'h5555_0000;
        repeat (2) @(posedge iClk);
        #2;
        chk("rst_mid_active", 64'(|bus_v), 64'd1);
        iReset_n = 1'b0;
        #1;
        chk("rst_async_strobes", {bus_v, bus_we}, 64'd0);
        chk("rst_async_busy", 64'(oBusy), 64'd0);
        chk("rst_async_wr_ready", 64'(oWr_Ready), 64'd0);
        iWr_Valid = 1'b0; clr_mem = 1'b1;
        @(posedge iClk); #1;
        iReset_n = 1'b1; clr_mem = 1'b0;
        @(negedge iClk);
        chk("rst_release_cmd_ready", 64'(oCmd_Ready), 64'd1);
        @(posedge iClk); #1;
        mon_en = 1'b1;

        // Scatter write with busy-command injection, then gather read with backpressure
        wdata = {32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
        run_cmd(1'b1, 1'b0, 5, 6, 0, 1'b1, dc);
        chk("scatter_cycles", 64'(dc), 64'd6);
        run_cmd(1'b0, 1'b0, 5, 6, 1, 1'b0, dc);

        // Zero count
        run_cmd(1'b1, 1'b0, 7, 0, 0, 1'b0, dc);
        chk("zero_count_write_done", 64'(dc), 64'd0);
        run_cmd(1'b0, 1'b0, 9, 0, 0, 1'b0, dc);
        chk("zero_count_read_done", 64'(dc), 64'd0);

        // Row wrap-around
        wdata.delete();
        for (int i = 0; i < 8; i++) wdata.push_back(DW'($urandom));
        run_cmd(1'b1, 1'b0, 10'h3FF, 8, 0, 1'b0, dc);
        run_cmd(1'b0, 1'b0, 10'h3FF, 8, 2, 1'b0, dc);

        // Broadcast write, then read both rows across all lanes
        wdata = {32'hA, 32'hB};
        run_cmd(1'b1, 1'b1, 2, 2, 0, 1'b0, dc);
        run_cmd(1'b0, 1'b1, 2, 8, 0, 1'b0, dc);
        chk("read_full_rate_cycles", 64'(dc), 64'd24);

        // Randomized command mix
        for (int n = 0; n < 30; n++) begin
            int cnt;
            int base;
            bit wr;
            cnt  = $urandom_range(0, 12);
            base = $urandom_range(0, ROWS - 1);
            wr   = (n % 2 == 0);
            if (!wr) base = $urandom_range(0, 3) == 0 ? base : (base & 32'h3F0);
            if (wr) base = base & 32'h3F0;
            wdata.delete();
            for (int i = 0; i < cnt; i++) wdata.push_back(DW'($urandom));
            run_cmd(wr, 1'($urandom % 2), base, cnt, $urandom_range(0, 2), 1'($urandom % 2), dc);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
